spi_flash_page_write: RTL and testbench

- SPI flash page-program initiator: the write-side counterpart of the flash read path.
- Takes a start address, a byte count and a byte stream, then runs WREN → Page Program (4-byte address) → status polling until WIP clears.
- Sits beside the read engine on the same ROM SPI pins, under the same top-level bus-select control (PCH/BMC select, busy/completed flags).
- Single-bit SPI, mode 0, MSB first.

---
 rtl/spi_flash_pkg.sv | 36 +++
 rtl/spi_byte_shifter.sv | 68 ++++++
 rtl/spi_flash_page_write.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_flash_page_write.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state encoding and page rules for the SPI flash write engine.
// No logic of its own; zero latency.
// No flow control here; consumers own their handshakes.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP4B = 8'h12;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int PAGE_BYTES = 256;
    localparam int WIP        = 0;
    localparam int WEL        = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_WREN,
        S_GAP1,
        S_WEL_CMD,
        S_WEL_RD,
        S_PP_HDR,
        S_PP_DATA,
        S_GAP2,
        S_RDSR,
        S_POLL,
        S_DONE,
        S_ERR
    } state_t;

    // Offset + count is formed at 10 bits so a count near 511 cannot wrap back into range.
    function automatic logic page_violation(input logic [7:0] offset, input logic [8:0] count);
        return (count == 9'd0) || (count > 9'(PAGE_BYTES)) ||
               (({2'b00, offset} + {1'b0, count}) > 10'(PAGE_BYTES));
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0, MSB-first single-bit SPI byte shifter that also generates spi_clk.
// Latency: 16*CLK_DIV cycles from load to done; rx_byte is valid with done.
// Backpressure: load is ignored while busy; spi_clk rests low between bytes.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       busy,
    output logic       spi_clk,
    output logic       mosi
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [3:0]    half_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            spi_clk <= 1'b0;
            div_q   <= '0;
            half_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            done <= 1'b0;
            if (load && !busy) begin
                busy    <= 1'b1;
                tx_q    <= tx_byte;
                div_q   <= '0;
                half_q  <= '0;
                spi_clk <= 1'b0;
            end else if (busy) begin
                if (div_q == DIV_LAST) begin
                    div_q   <= '0;
                    spi_clk <= ~spi_clk;
                    half_q  <= half_q + 4'd1;
                    if (!spi_clk) begin
                        rx_q <= {rx_q[6:0], miso};
                    end else if (half_q == 4'd15) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        // Next MOSI bit only moves on a falling edge.
                        tx_q <= {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end
        end
    end

    assign mosi    = tx_q[7];
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_flash_page_write.sv
// SPI flash page program: WREN, 4-byte-address Page Program, RDSR poll until WIP clears.
// Latency: first cs_n fall 2 cycles after start; optional WEL readback under SPI_FLASH_VERIFY_WEL_EN.
// Backpressure: wr_ready only when the shifter is idle; a missing byte stalls with spi_clk low, cs_n low.
module spi_flash_page_write
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CS_HIGH_CYC = 4,
    parameter int POLL_MAX    = 65535
) (
    input  logic        system_clk,
    input  logic        system_reset_n,
    input  logic        start_flag,
    input  logic [31:0] start_addr,
    input  logic [8:0]  byte_count,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        write_finish,
    output logic        error,
    output logic        spi_clk,
    output logic        cs_n,
    inout  wire         sfr2qspi_io0,
    inout  wire         sfr2qspi_io1,
    inout  wire         sfr2qspi_io2,
    inout  wire         sfr2qspi_io3
);

    localparam int            GW        = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH_CYC - 1);
    localparam int            PW        = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    state_t        state_q, state_d;
    logic          cs_n_q, cs_n_d;
    logic [31:0]   addr_q;
    logic [8:0]    cnt_q;
    logic [8:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          sh_load, sh_done, sh_busy, mosi;
    logic [7:0]    sh_tx, sh_rx;
    logic          unused_rx;
`ifdef SPI_FLASH_VERIFY_WEL_EN
    logic          wel_ok_q, wel_ok_d;
`endif

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (system_clk),
        .rst_n   (system_reset_n),
        .load    (sh_load),
        .tx_byte (sh_tx),
        .miso    (sfr2qspi_io1),
        .rx_byte (sh_rx),
        .done    (sh_done),
        .busy    (sh_busy),
        .spi_clk (spi_clk),
        .mosi    (mosi)
    );

    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            addr_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            poll_q  <= '0;
`ifdef SPI_FLASH_VERIFY_WEL_EN
            wel_ok_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            poll_q  <= poll_d;
`ifdef SPI_FLASH_VERIFY_WEL_EN
            wel_ok_q <= wel_ok_d;
`endif
            if (state_q == S_IDLE && start_flag) begin
                addr_q <= start_addr;
                cnt_q  <= byte_count;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cs_n_d       = cs_n_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        poll_d       = poll_q;
        sh_load      = 1'b0;
        sh_tx        = 8'h00;
        wr_ready     = 1'b0;
        write_finish = 1'b0;
        error        = 1'b0;
`ifdef SPI_FLASH_VERIFY_WEL_EN
        wel_ok_d     = wel_ok_q;
`endif
        case (state_q)
            S_IDLE: if (start_flag) state_d = S_CHECK;
            S_CHECK: begin
`ifdef SPI_FLASH_VERIFY_WEL_EN
                wel_ok_d = 1'b0;
`endif
                if (page_violation(addr_q[7:0], cnt_q)) begin
                    state_d = S_ERR;
                end else begin
                    sh_load = 1'b1;
                    sh_tx   = OP_WREN;
                    cs_n_d  = 1'b0;
                    state_d = S_WREN;
                end
            end
            S_WREN: if (sh_done) begin
                cs_n_d  = 1'b1;
                gap_d   = '0;
                state_d = S_GAP1;
            end
            S_GAP1: if (gap_q == GAP_LAST) begin
                cs_n_d  = 1'b0;
                sh_load = 1'b1;
                idx_d   = '0;
`ifdef SPI_FLASH_VERIFY_WEL_EN
                sh_tx   = wel_ok_q ? OP_PP4B : OP_RDSR;
                state_d = wel_ok_q ? S_PP_HDR : S_WEL_CMD;
`else
                sh_tx   = OP_PP4B;
                state_d = S_PP_HDR;
`endif
            end else begin
                gap_d = gap_q + GW'(1);
            end
`ifdef SPI_FLASH_VERIFY_WEL_EN
            S_WEL_CMD: if (sh_done) begin
                sh_load = 1'b1;
                state_d = S_WEL_RD;
            end
            S_WEL_RD: if (sh_done) begin
                cs_n_d = 1'b1;
                gap_d  = '0;
                if (!sh_rx[WEL]) begin
                    state_d = S_ERR;
                end else begin
                    wel_ok_d = 1'b1;
                    state_d  = S_GAP1;
                end
            end
`endif
            // idx counts header bytes already sent: opcode, then address MSB first.
            S_PP_HDR: if (sh_done) begin
                if (idx_q == 9'd4) begin
                    idx_d   = '0;
                    state_d = S_PP_DATA;
                end else begin
                    sh_load = 1'b1;
                    idx_d   = idx_q + 9'd1;
                    case (idx_q[1:0])
                        2'd0:    sh_tx = addr_q[31:24];
                        2'd1:    sh_tx = addr_q[23:16];
                        2'd2:    sh_tx = addr_q[15:8];
                        default: sh_tx = addr_q[7:0];
                    endcase
                end
            end
            S_PP_DATA: if (!sh_busy) begin
                if (idx_q != cnt_q) begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        sh_load = 1'b1;
                        sh_tx   = wr_data;
                        idx_d   = idx_q + 9'd1;
                    end
                end else begin
                    cs_n_d  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP2;
                end
            end
            S_GAP2: if (gap_q == GAP_LAST) begin
                cs_n_d  = 1'b0;
                sh_load = 1'b1;
                sh_tx   = OP_RDSR;
                state_d = S_RDSR;
            end else begin
                gap_d = gap_q + GW'(1);
            end
            S_RDSR: if (sh_done) begin
                sh_load = 1'b1;
                poll_d  = '0;
                state_d = S_POLL;
            end
            S_POLL: if (sh_done) begin
                if (!sh_rx[WIP]) begin
                    cs_n_d  = 1'b1;
                    state_d = S_DONE;
                end else if (poll_q == POLL_LAST) begin
                    cs_n_d  = 1'b1;
                    state_d = S_ERR;
                end else begin
                    sh_load = 1'b1;
                    poll_d  = poll_q + PW'(1);
                end
            end
            S_DONE: begin
                write_finish = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign cs_n         = cs_n_q;
    assign unused_rx    = ^sh_rx;
    assign sfr2qspi_io0 = cs_n_q ? 1'bz : mosi;
    assign sfr2qspi_io2 = system_reset_n ? 1'b1 : 1'bz;
    assign sfr2qspi_io3 = system_reset_n ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_spi_flash_page_write.sv
// Directed bench for spi_flash_page_write with a behavioural SPI flash model on the pins.
module tb_spi_flash_page_write;

    logic        system_clk = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        start_flag = 1'b0;
    logic [31:0] start_addr = '0;
    logic [8:0]  byte_count = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    wire         wr_ready, busy, write_finish, error, spi_clk, cs_n;
    wire         io0, io1, io2, io3;
    logic        miso = 1'b0;

    int checks = 0;
    int errors = 0;

    assign io1 = miso;

    spi_flash_page_write #(.CLK_DIV(2), .CS_HIGH_CYC(4), .POLL_MAX(10)) dut (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .start_flag     (start_flag),
        .start_addr     (start_addr),
        .byte_count     (byte_count),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .write_finish   (write_finish),
        .error          (error),
        .spi_clk        (spi_clk),
        .cs_n           (cs_n),
        .sfr2qspi_io0   (io0),
        .sfr2qspi_io1   (io1),
        .sfr2qspi_io2   (io2),
        .sfr2qspi_io3   (io3)
    );

    always #5 system_clk = ~system_clk;

    // Flash model: logs every non-status byte, answers RDSR with WIP set until stat_idx reaches wip_until.
    logic [7:0] sh_in = '0;
    logic [7:0] cur_stat = '0;
    logic [7:0] mlog[$];
    int bitn = 0, nbytes = 0, obit = 0, stat_idx = 0, wip_until = 0, status_reads = 0;
    bit rdsr = 0;
    int fin_cnt = 0, err_cnt = 0, cs_falls = 0;

    always @(posedge spi_clk or posedge cs_n) begin
        if (cs_n) begin
            bitn = 0; nbytes = 0; rdsr = 0;
        end else begin
            sh_in = {sh_in[6:0], io0};
            bitn++;
            if (bitn == 8) begin
                bitn = 0;
                if (nbytes == 0) begin
                    mlog.push_back(sh_in);
                    rdsr = (sh_in == 8'h05);
                end else if (rdsr) status_reads++;
                else mlog.push_back(sh_in);
                nbytes++;
            end
        end
    end

    always @(negedge spi_clk) begin
        if (cs_n === 1'b0 && rdsr) begin
            if (obit == 0) begin
                cur_stat = (stat_idx < wip_until) ? 8'h03 : 8'h02;
                stat_idx++;
            end
            miso = cur_stat[7-obit];
            obit = (obit + 1) % 8;
        end else begin
            obit = 0;
        end
    end

    always @(posedge system_clk) begin
        if (write_finish) fin_cnt++;
        if (error) err_cnt++;
    end
    always @(negedge cs_n) cs_falls++;

    logic [7:0] dq [16];

    task automatic do_start(input logic [31:0] a, input logic [8:0] n);
        @(negedge system_clk);
        start_addr = a; byte_count = n; start_flag = 1'b1;
        @(negedge system_clk);
        start_flag = 1'b0;
    endtask

    task automatic feed(input int first, input int last, output bit ok);
        int i = first;
        int guard = 0;
        while (i < last && guard < 2000) begin
            wr_data = dq[i]; wr_valid = 1'b1;
            if (wr_ready === 1'b1) i++;
            @(negedge system_clk);
            guard++;
        end
        wr_valid = 1'b0;
        ok = (i == last);
    endtask

    task automatic wait_end(input int maxc, output bit fin, output bit er);
        fin = 0; er = 0;
        for (int c = 0; c < maxc && !fin && !er; c++) begin
            @(negedge system_clk);
            fin = write_finish; er = error;
        end
    endtask

    task automatic test_reset();
        @(negedge system_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (write_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", write_finish); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_spi_clk got %b want 0", spi_clk); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        system_reset_n = 1'b1;
        repeat (2) @(negedge system_clk);
        checks++; if (io2 !== 1'b1 || io3 !== 1'b1) begin errors++; $display("FAIL wp_hold got %b%b want 11", io2, io3); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_normal();
        logic [7:0] exp_b [11] = '{8'h06, 8'h12, 8'h00, 8'h00, 8'h10, 8'h00, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h05};
        int b_log = mlog.size(), b_sr = status_reads, b_fin = fin_cnt, b_err = err_cnt;
        bit ok, fin, er;
        logic [7:0] got;
        dq[0] = 8'hA5; dq[1] = 8'h5A; dq[2] = 8'h00; dq[3] = 8'hFF;
        wip_until = stat_idx + 3;
        do_start(32'h0000_1000, 9'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy_rise got %b want 1", busy); end
        @(negedge system_clk);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL normal_cs_latency got %b want 0", cs_n); end
        feed(0, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL normal_feed got timeout want 4 bytes"); end
        wait_end(3000, fin, er);
        checks++; if (fin !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL normal_finish got fin=%b err=%b want 1 0", fin, er); end
        @(negedge system_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_fall got %b want 0", busy); end
        repeat (3) @(negedge system_clk);
        checks++; if (mlog.size() - b_log != 11) begin errors++; $display("FAIL normal_log_len got %0d want 11", mlog.size() - b_log); end
        for (int k = 0; k < 11; k++) begin
            got = (b_log + k < mlog.size()) ? mlog[b_log + k] : 8'hxx;
            checks++; if (got !== exp_b[k]) begin errors++; $display("FAIL normal_mosi[%0d] got %h want %h", k, got, exp_b[k]); end
        end
        checks++; if (status_reads - b_sr != 4) begin errors++; $display("FAIL normal_status_reads got %0d want 4", status_reads - b_sr); end
        checks++; if (fin_cnt - b_fin != 1 || err_cnt != b_err) begin errors++; $display("FAIL normal_pulses got fin=%0d err=%0d want 1 0", fin_cnt - b_fin, err_cnt - b_err); end
    endtask

    task automatic test_page_cross();
        int b_fall = cs_falls, b_err = err_cnt;
        do_start(32'h0000_10F0, 9'd17);
        @(negedge system_clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL cross_error got %b want 1", error); end
        @(negedge system_clk);
        checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cross_after got err=%b busy=%b want 0 0", error, busy); end
        checks++; if (cs_falls != b_fall || err_cnt - b_err != 1) begin errors++; $display("FAIL cross_activity got falls=%0d errs=%0d want 0 1", cs_falls - b_fall, err_cnt - b_err); end
    endtask

    task automatic test_count_bounds();
        logic [8:0] bad_n [2] = '{9'd0, 9'd257};
        int b_fall = cs_falls;
        for (int k = 0; k < 2; k++) begin
            do_start(32'h0000_0000, bad_n[k]);
            @(negedge system_clk);
            checks++; if (error !== 1'b1) begin errors++; $display("FAIL count_%0d_error got %b want 1", bad_n[k], error); end
            @(negedge system_clk);
        end
        checks++; if (cs_falls != b_fall) begin errors++; $display("FAIL count_cs_activity got %0d want 0", cs_falls - b_fall); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_b [14] = '{8'h06, 8'h12, 8'h00, 8'h00, 8'h20, 8'h00,
                                   8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int b_log = mlog.size();
        bit ok, fin, er, bad = 0;
        logic [7:0] got;
        for (int k = 0; k < 8; k++) dq[k] = 8'(8'h11 * (k + 1));
        wip_until = stat_idx;
        do_start(32'h0000_2000, 9'd8);
        feed(0, 2, ok);
        for (int c = 0; c < 50; c++) begin
            @(negedge system_clk);
            if (c >= 36 && (spi_clk !== 1'b0 || cs_n !== 1'b0)) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_pins got clk/cs moving want both held low"); end
        feed(2, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_feed got timeout want 8 bytes"); end
        wait_end(3000, fin, er);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL stall_finish got %b want 1", fin); end
        for (int k = 0; k < 14; k++) begin
            got = (b_log + k < mlog.size()) ? mlog[b_log + k] : 8'hxx;
            checks++; if (got !== exp_b[k]) begin errors++; $display("FAIL stall_mosi[%0d] got %h want %h", k, got, exp_b[k]); end
        end
    endtask

    task automatic test_timeout();
        int b_sr = status_reads;
        bit ok, fin, er;
        dq[0] = 8'h3C;
        wip_until = stat_idx + 1000;
        do_start(32'h0000_3000, 9'd1);
        feed(0, 1, ok);
        wait_end(5000, fin, er);
        checks++; if (er !== 1'b1 || fin !== 1'b0) begin errors++; $display("FAIL timeout_error got err=%b fin=%b want 1 0", er, fin); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL timeout_cs_n got %b want 1", cs_n); end
        checks++; if (status_reads - b_sr != 10) begin errors++; $display("FAIL timeout_status_reads got %0d want 10", status_reads - b_sr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [9] = '{8'h06, 8'h12, 8'h00, 8'h00, 8'h50, 8'h00, 8'hC3, 8'h3C, 8'h05};
        int b_log;
        bit ok, fin, er, high = 0;
        logic [7:0] got;
        for (int k = 0; k < 4; k++) dq[k] = 8'(8'h40 + k);
        do_start(32'h0000_4000, 9'd4);
        feed(0, 2, ok);
        for (int g = 0; g < 100 && !high; g++) begin
            @(posedge system_clk); #1;
            high = spi_clk;
        end
        checks++; if (!high) begin errors++; $display("FAIL midreset_setup got spi_clk low want high in PP_DATA"); end
        #2 system_reset_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1 || spi_clk !== 1'b0) begin errors++; $display("FAIL midreset_pins got cs_n=%b clk=%b want 1 0", cs_n, spi_clk); end
        @(negedge system_clk);
        system_reset_n = 1'b1;
        b_log = mlog.size();
        dq[0] = 8'hC3; dq[1] = 8'h3C;
        wip_until = stat_idx + 1;
        do_start(32'h0000_5000, 9'd2);
        feed(0, 2, ok);
        wait_end(3000, fin, er);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL midreset_finish got %b want 1", fin); end
        for (int k = 0; k < 9; k++) begin
            got = (b_log + k < mlog.size()) ? mlog[b_log + k] : 8'hxx;
            checks++; if (got !== exp_b[k]) begin errors++; $display("FAIL midreset_mosi[%0d] got %h want %h", k, got, exp_b[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_page_cross();
        test_count_bounds();
        test_stall();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge system_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
